key_debounce: RTL

Multi-channel push-button debouncer driven by the tick pulse of the counter-based clock divider. It sits directly downstream of the divider: the divider's one-cycle `clkdiv` output feeds `tick` here. Raw asynchronous KEY inputs are synchronised into `clk`, qualified over consecutive ticks, and presented as clean levels plus one-cycle press and release strobes for the application logic.

---
 rtl/de10_pkg.sv | 18 +
 rtl/key_debounce_ch.sv | 111 +++++++++++
 rtl/key_debounce.sv | 33 +++
 3 files changed

// File: rtl/de10_pkg.sv
// de10_pkg: shared state encoding and defaults for the key debouncer
package de10_pkg;

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_CHK_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_CHK_RELEASE = 2'd3;

    localparam int DEFAULT_STABLE_COUNT = 4;

    typedef enum logic [1:0] {
        RELEASED    = ST_RELEASED,
        CHK_PRESS   = ST_CHK_PRESS,
        PRESSED     = ST_PRESSED,
        CHK_RELEASE = ST_CHK_RELEASE
    } state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel -- synchroniser, qualification FSM and registered strobes
module key_debounce_ch
    import de10_pkg::*;
#(
    parameter int STABLE_COUNT   = DEFAULT_STABLE_COUNT,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

    logic          sync1;
    logic          sync2;
    logic          pressed_s;
    state_e        state;
    logic [CW-1:0] cnt;

    // two-flop synchroniser, reset to the released pin level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= KEY_ACTIVE_LOW;
            sync2 <= KEY_ACTIVE_LOW;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign pressed_s = sync2 ^ KEY_ACTIVE_LOW;

    // qualification FSM; any disagreeing sample drops back to the stable state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RELEASED;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (tick) begin
                case (state)
                    RELEASED: begin
                        if (pressed_s) begin
                            if (STABLE_COUNT == 1) begin
                                state     <= PRESSED;
                                key_level <= 1'b1;
                                key_press <= 1'b1;
                            end else begin
                                state <= CHK_PRESS;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    CHK_PRESS: begin
                        if (!pressed_s) begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end else if (cnt == LAST) begin
                            state     <= PRESSED;
                            cnt       <= '0;
                            key_level <= 1'b1;
                            key_press <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!pressed_s) begin
                            if (STABLE_COUNT == 1) begin
                                state       <= RELEASED;
                                key_level   <= 1'b0;
                                key_release <= 1'b1;
                            end else begin
                                state <= CHK_RELEASE;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    CHK_RELEASE: begin
                        if (pressed_s) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == LAST) begin
                            state       <= RELEASED;
                            cnt         <= '0;
                            key_level   <= 1'b0;
                            key_release <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/key_debounce.sv
// key_debounce: NUM_KEYS independent debounced key channels sampled on the divider tick
module key_debounce
    import de10_pkg::*;
#(
    parameter int NUM_KEYS       = 2,
    parameter int STABLE_COUNT   = DEFAULT_STABLE_COUNT,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .STABLE_COUNT  (STABLE_COUNT),
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .key_in     (key_in[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

endmodule
